// File: rtl/decoder_rr_arbiter_if.sv
// Bundle between the 8 requesters and the round-robin arbiter that owns the shared select resource.
interface decoder_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       preempt;

    modport master (
        output req,
        output done,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot,
        input  preempt
    );

    modport slave (
        input  req,
        input  done,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot,
        output preempt
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters with a bounded hold time; the registered grant index
// feeds a 3-to-8 decoder that produces the one-hot resource select.
module decoder_3to8 (
    input  logic [2:0] in,
    output logic [7:0] out
);
    assign out = 8'b1 << in;
endmodule

module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last hold cycle before a forced revoke; unused (and harmless) when MAX_HOLD is 0.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       last_q;
    logic [2:0]       gnt_idx_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             preempt_q;

    logic [2:0]       winner;
    logic [2:0]       scan;
    logic             found;
    logic             any_req;
    logic [7:0]       others;
    logic             rel_now;
    logic             preempt_now;
    logic [7:0]       dec_out;

    // Rotating priority: the requester right after the previous owner is looked at first,
    // so the previous owner itself comes last.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        winner = last_q;
        found  = 1'b0;
        scan   = last_q;
        for (int i = 1; i <= 8; i++) begin
            scan = last_q + 3'(i);
            if (!found && bus.req[scan]) begin
                winner = scan;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |bus.req;
    assign others  = bus.req & ~(8'b1 << gnt_idx_q);

    // A release always wins over the hold limit, so a preempt pulse only marks a forced revoke.
    always_comb begin
        rel_now     = bus.done[gnt_idx_q] | ~bus.req[gnt_idx_q];
        preempt_now = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && (|others) && !rel_now;
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)                state_d = GRANT;
            GRANT:   if (rel_now || preempt_now) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 3'd7;
            gnt_idx_q  <= 3'd0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= (state_q == GRANT) && preempt_now;
            if (state_q == IDLE) begin
                if (any_req) begin
                    gnt_idx_q  <= winner;
                    last_q     <= winner;
                    hold_cnt_q <= '0;
                end
            end else if (!rel_now && !preempt_now && (hold_cnt_q != HOLD_LAST)) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

    decoder_3to8 u_dec (
        .in  (gnt_idx_q),
        .out (dec_out)
    );

    // Output logic
    always_comb begin
        bus.gnt_valid  = (state_q == GRANT);
        bus.gnt_idx    = gnt_idx_q;
        bus.gnt_onehot = (state_q == GRANT) ? dec_out : 8'h00;
        bus.preempt    = preempt_q;
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: expected grant state per cycle is queued at drive time
// and compared one clock later.
module tb_decoder_rr_arbiter;

    typedef struct {
        string      tag;
        logic       valid;
        logic [2:0] idx;
        logic       preempt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the state after the coming edge, clock, then pop and compare.
    task automatic cyc(input string tag, input logic v, input logic [2:0] i, input logic p);
        exp_t e;
        exp_t got;
        e.tag = tag; e.valid = v; e.idx = i; e.preempt = p;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".valid"},   8'(bus.gnt_valid),  8'(got.valid));
        check({got.tag, ".idx"},     8'(bus.gnt_idx),    8'(got.idx));
        check({got.tag, ".onehot"},  bus.gnt_onehot,     got.valid ? (8'h01 << got.idx) : 8'h00);
        check({got.tag, ".preempt"}, 8'(bus.preempt),    8'(got.preempt));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        cyc(tag, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bus.req  = 8'h00;
        bus.done = 8'h00;

        // 1: reset, then idle with no requests
        do_reset("rst0");
        repeat (5) cyc("idle", 1'b0, 3'd0, 1'b0);

        // 2: single requester, foreign done ignored, own done releases
        bus.req = 8'h01;
        cyc("single_n1", 1'b1, 3'd0, 1'b0);
        bus.done = 8'h02;
        cyc("single_n2", 1'b1, 3'd0, 1'b0);
        bus.done = 8'h00;
        cyc("single_n3", 1'b1, 3'd0, 1'b0);
        cyc("single_n4", 1'b1, 3'd0, 1'b0);
        bus.done = 8'h01;
        cyc("single_n5", 1'b0, 3'd0, 1'b0);
        bus.done = 8'h00;
        bus.req  = 8'h00;
        cyc("single_idle", 1'b0, 3'd0, 1'b0);

        // 3: all requesting, rotation 0..7 and wrap to 0 with one idle cycle between grants
        do_reset("rst1");
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            cyc($sformatf("rr%0d_a", k), 1'b1, 3'(k), 1'b0);
            cyc($sformatf("rr%0d_b", k), 1'b1, 3'(k), 1'b0);
            bus.done = 8'h01 << (k % 8);
            cyc($sformatf("rr%0d_gap", k), 1'b0, 3'(k), 1'b0);
            bus.done = 8'h00;
        end
        bus.req = 8'h00;
        cyc("rr_end", 1'b0, 3'd0, 1'b0);

        // 4: hold limit with a competitor, then release coinciding with the limit
        do_reset("rst2");
        bus.req = 8'h05;
        for (int c = 0; c < 16; c++) cyc($sformatf("hold0_%0d", c), 1'b1, 3'd0, 1'b0);
        cyc("preempt0", 1'b0, 3'd0, 1'b1);
        for (int c = 0; c < 16; c++) cyc($sformatf("hold2_%0d", c), 1'b1, 3'd2, 1'b0);
        cyc("preempt2", 1'b0, 3'd2, 1'b1);
        for (int c = 0; c < 16; c++) cyc($sformatf("hold0b_%0d", c), 1'b1, 3'd0, 1'b0);
        bus.done = 8'h01;
        cyc("rel_beats_preempt", 1'b0, 3'd0, 1'b0);
        bus.done = 8'h00;
        bus.req  = 8'h00;
        cyc("hold_end", 1'b0, 3'd0, 1'b0);

        // 5: lone requester is never preempted
        bus.req = 8'h08;
        for (int c = 0; c < 40; c++) cyc($sformatf("lone_%0d", c), 1'b1, 3'd3, 1'b0);
        bus.req = 8'h00;
        cyc("lone_rel", 1'b0, 3'd3, 1'b0);

        // 6: reset mid-grant restores last=7
        bus.req = 8'h20;
        cyc("mid_a", 1'b1, 3'd5, 1'b0);
        cyc("mid_b", 1'b1, 3'd5, 1'b0);
        bus.req = 8'h21;
        do_reset("rst_mid");
        cyc("after_rst", 1'b1, 3'd0, 1'b0);
        bus.req = 8'h00;
        cyc("final", 1'b0, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
